// File: rtl/mem_pkg.sv
// Shared definitions for the pipelined data memory: default widths,
// byte-enable width helper and the response payload layout.
package mem_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 15;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } resp_t;
endpackage

// File: rtl/resp_fifo.sv
// First-word-fall-through FIFO with occupancy count; head data reads as zero
// when empty so downstream outputs are clean during and after reset.
module resp_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_valid = (r_cnt != '0);
  assign w_pop   = o_valid && i_pop;
  assign o_data  = o_valid ? r_mem[r_rp] : '0;
  assign o_count = r_cnt;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  // Upstream credit keeps pushes within capacity; push+pop when full is legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: rtl/data_memory_pipelined.sv
// Word-addressed RAM with byte-enable writes, configurable read latency and
// credit-based request flow control against a response FIFO.
module data_memory_pipelined import mem_pkg::*; #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = READ_LATENCY + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_we,
  input  logic [ADDR_WIDTH-1:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  input  logic [be_width(DATA_WIDTH)-1:0]   req_be,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  output logic                              resp_err,
  output logic                              wr_err
);
  localparam int BE_W  = be_width(DATA_WIDTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } resp_w_t;

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic                   r_run;
  logic                   r_wr_err;
  logic [READ_LATENCY:1]  r_vld_pipe;
  resp_w_t                r_pl [READ_LATENCY:1];
  logic [CNT_W-1:0]       r_inflight;

  logic                   w_in_range, w_acc, w_rd_acc, w_wr_ok, w_credit, w_push;
  logic [IDX_W-1:0]       w_idx;
  logic [CNT_W-1:0]       w_fifo_cnt;
  resp_w_t                w_head;

  assign w_in_range = ({1'b0, req_addr} < DEPTH_L);
  assign w_idx      = req_addr[IDX_W-1:0];

  // Credit uses only registered counts, so resp_ready never reaches req_ready.
  assign w_credit  = ({1'b0, r_inflight} + {1'b0, w_fifo_cnt}) < (CNT_W + 1)'(RESP_DEPTH);
  assign req_ready = r_run && (req_we || w_credit);
  assign w_acc     = req_valid && req_ready;
  assign w_rd_acc  = w_acc && !req_we;
  assign w_wr_ok   = w_acc && req_we && w_in_range;
  assign w_push    = r_vld_pipe[READ_LATENCY];
  assign wr_err    = r_wr_err;

  always_ff @(posedge clk) begin
    if (w_wr_ok)
      for (int b = 0; b < BE_W; b++)
        if (req_be[b]) r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
  end

  // Stage 1 samples the array on the accept edge, so a same-edge write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_wr_err   <= 1'b0;
      r_vld_pipe <= '0;
      r_inflight <= '0;
      for (int s = 1; s <= READ_LATENCY; s++) r_pl[s] <= '0;
    end else begin
      r_run         <= 1'b1;
      r_wr_err      <= w_acc && req_we && !w_in_range;
      r_vld_pipe[1] <= w_rd_acc;
      r_pl[1].rdata <= w_in_range ? r_mem[w_idx] : '0;
      r_pl[1].err   <= !w_in_range;
      for (int s = 2; s <= READ_LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_pl[s]       <= r_pl[s-1];
      end
      r_inflight <= r_inflight + CNT_W'(w_rd_acc) - CNT_W'(w_push);
    end
  end

  resp_fifo #(
    .WIDTH ($bits(resp_w_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_pl[READ_LATENCY]),
    .i_pop   (resp_ready),
    .o_valid (resp_valid),
    .o_data  (w_head),
    .o_count (w_fifo_cnt)
  );

  assign resp_rdata = w_head.rdata;
  assign resp_err   = w_head.err;
endmodule
